// File: rtl/measure_scheduler.sv
// Purpose: time-shares one signal measurer across NUM_CH inputs and banks per-channel results.
// Latency: SETTLE_CYC + 1 + measurer time + 1 cycles per enabled channel.
// Backpressure: none; start is ignored while busy or gapping, and a silent measurer is cut off by the timeout.
module measure_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_en,
    input  logic [31:0]       interval,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] sig_in,
    output logic              meas_sig,
    output logic              meas_enable,
    input  logic              meas_finish,
    input  logic [25:0]       meas_freq,
    input  logic [7:0]        meas_duty,
    input  logic [19:0]       meas_high,
    input  logic [19:0]       meas_low,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [25:0]       rd_freq,
    output logic [7:0]        rd_duty,
    output logic [19:0]       rd_high,
    output logic [19:0]       rd_low,
    output logic              rd_valid,
    output logic              rd_timeout,
    output logic              busy,
    output logic [CH_W-1:0]   cur_ch,
    output logic              sweep_done
);

    // Bank is sized to the full index space so out-of-range reads hit never-written zero entries.
    localparam int DEPTH = 1 << CH_W;

    typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT, STORE, GAP} state_t;

    state_t            state, state_n;
    logic [NUM_CH-1:0] mask_q;
    logic [31:0]       cnt;
    logic [25:0]       res_freq;
    logic [7:0]        res_duty;
    logic [19:0]       res_high;
    logic [19:0]       res_low;
    logic              res_tout;
    logic [CH_W-1:0]   first_idx;
    logic [CH_W-1:0]   nxt_idx;
    logic              nxt_vld;
    logic              timed_out;
    logic              gap_end;
    logic              launch;

    logic [25:0]       bank_freq [DEPTH];
    logic [7:0]        bank_duty [DEPTH];
    logic [19:0]       bank_high [DEPTH];
    logic [19:0]       bank_low  [DEPTH];
    logic [DEPTH-1:0]  bank_valid;
    logic [DEPTH-1:0]  bank_tout;

    // Descending scan leaves the lowest qualifying bit in each result.
    always_comb begin
        first_idx = '0;
        nxt_idx   = '0;
        nxt_vld   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_idx = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(cur_ch))) begin
                nxt_idx = CH_W'(i);
                nxt_vld = 1'b1;
            end
        end
    end

    assign timed_out = (cnt == 32'(TIMEOUT_CYC - 1));
    assign gap_end   = ((cnt + 32'd1) >= interval);

    always_comb begin
        state_n     = state;
        meas_enable = 1'b0;
        sweep_done  = 1'b0;
        case (state)
            IDLE:   if (start && (ch_mask != '0)) state_n = SETTLE;
            SETTLE: if (cnt == 32'(SETTLE_CYC - 1)) state_n = TRIG;
            TRIG: begin
                meas_enable = 1'b1;
                state_n     = WAIT;
            end
            WAIT:   if (meas_finish || timed_out) state_n = STORE;
            STORE: begin
                if (nxt_vld) begin
                    state_n = SETTLE;
                end else begin
                    sweep_done = 1'b1;
                    state_n    = auto_en ? GAP : IDLE;
                end
            end
            GAP: begin
                if (!auto_en) begin
                    state_n = IDLE;
                end else if (gap_end) begin
                    state_n = (ch_mask != '0) ? SETTLE : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign launch = ((state == IDLE) || (state == GAP)) && (state_n == SETTLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mask_q     <= '0;
            cur_ch     <= '0;
            busy       <= 1'b0;
            meas_sig   <= 1'b0;
            res_freq   <= '0;
            res_duty   <= '0;
            res_high   <= '0;
            res_low    <= '0;
            res_tout   <= 1'b0;
            bank_valid <= '0;
            bank_tout  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_freq[i] <= '0;
                bank_duty[i] <= '0;
                bank_high[i] <= '0;
                bank_low[i]  <= '0;
            end
        end else begin
            state    <= state_n;
            meas_sig <= sig_in[cur_ch];
            // Every state change restarts the shared settle/timeout/gap counter.
            cnt      <= (state_n != state) ? 32'd0 : cnt + 32'd1;

            if (launch) begin
                mask_q <= ch_mask;
                cur_ch <= first_idx;
                busy   <= 1'b1;
            end

            if (state == WAIT) begin
                if (meas_finish) begin
                    res_freq <= meas_freq;
                    res_duty <= meas_duty;
                    res_high <= meas_high;
                    res_low  <= meas_low;
                    res_tout <= 1'b0;
                end else if (timed_out) begin
                    res_freq <= '0;
                    res_duty <= '0;
                    res_high <= '0;
                    res_low  <= '0;
                    res_tout <= 1'b1;
                end
            end

            if (state == STORE) begin
                bank_freq[cur_ch]  <= res_freq;
                bank_duty[cur_ch]  <= res_duty;
                bank_high[cur_ch]  <= res_high;
                bank_low[cur_ch]   <= res_low;
                bank_valid[cur_ch] <= 1'b1;
                bank_tout[cur_ch]  <= res_tout;
                if (nxt_vld) begin
                    cur_ch <= nxt_idx;
                end else begin
                    busy <= 1'b0;
                end
            end
        end
    end

    assign rd_freq    = bank_freq[rd_ch];
    assign rd_duty    = bank_duty[rd_ch];
    assign rd_high    = bank_high[rd_ch];
    assign rd_low     = bank_low[rd_ch];
    assign rd_valid   = bank_valid[rd_ch];
    assign rd_timeout = bank_tout[rd_ch];

endmodule
